// File: rtl/dmx_pkg.sv
// Shared DMX definitions: universe size and the readback transmitter state encoding.
package dmx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREFETCH = 2'd1,
        SHIFT    = 2'd2,
        DONE     = 2'd3
    } spi_tx_state_t;

    localparam int DMX_UNIVERSE_BYTES = 512;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous level, with one-cycle rise/fall pulses
// taken from the last two stages of the chain.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    // sync[0] is the newest sample, sync[SYNC_STAGES-1] the oldest
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    assign rise = sync[SYNC_STAGES-2] & ~sync[SYNC_STAGES-1];
    assign fall = ~sync[SYNC_STAGES-2] & sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_readback_tx.sv
// SPI mode-0 slave transmitter streaming channel-buffer bytes (MSB first) to the MCU.
// state    | meaning
// IDLE     | waiting for load rise; sdo held low
// PREFETCH | byte 0 read in flight, captured into the shift register
// SHIFT    | shifting on sck falls; next byte prefetched into hold
// DONE     | one-cycle xfer_done pulse, then back to IDLE
module spi_readback_tx
    import dmx_pkg::*;
#(
    parameter int NUM_BYTES   = DMX_UNIVERSE_BYTES,
    parameter int AW          = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          sck,
    input  logic          load,
    output logic          sdo,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [7:0]    rd_data,
    output logic          busy,
    output logic          xfer_done,
    output logic [AW:0]   bytes_sent
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(NUM_BYTES - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW:0]   COUNT_ONE = (AW+1)'(1);

    spi_tx_state_t state, state_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    hold, hold_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic          rd_en_n;
    logic [AW-1:0] rd_addr_n, addr_inc;
    logic [AW:0]   bytes_sent_n, count_inc;
    logic          rd_en_d;
    logic          load_pend, load_pend_n;
    logic          sck_fall, sck_rise_unused;
    logic          load_rise, load_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (sck),
        .rise   (sck_rise_unused),
        .fall   (sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
        .sysclk (sysclk),
        .reset  (reset),
        .d      (load),
        .rise   (load_rise),
        .fall   (load_fall)
    );

    assign addr_inc  = (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_ONE;
    assign count_inc = (bytes_sent == '1) ? bytes_sent : bytes_sent + COUNT_ONE;

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        hold_n       = hold;
        bitcnt_n     = bitcnt;
        rd_en_n      = 1'b0;
        rd_addr_n    = rd_addr;
        bytes_sent_n = bytes_sent;
        load_pend_n  = 1'b0;

        // rd_data is valid the cycle after a strobe; only SHIFT owns the hold register
        if (state == SHIFT && rd_en_d) begin
            hold_n = rd_data;
        end

        case (state)
            IDLE: begin
                if (load_rise || load_pend) begin
                    rd_en_n      = 1'b1;
                    rd_addr_n    = '0;
                    bytes_sent_n = '0;
                    state_n      = PREFETCH;
                end
            end
            PREFETCH: begin
                if (load_fall) begin
                    state_n = DONE;
                end else if (rd_en_d) begin
                    shreg_n   = rd_data;
                    rd_en_n   = 1'b1;
                    rd_addr_n = addr_inc;
                    bitcnt_n  = 3'd0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                // load fall beats a coincident sck fall: the partial byte is dropped
                if (load_fall) begin
                    state_n = DONE;
                end else if (sck_fall) begin
                    if (bitcnt == 3'd7) begin
                        shreg_n      = hold;
                        bitcnt_n     = 3'd0;
                        bytes_sent_n = count_inc;
                        rd_addr_n    = addr_inc;
                        rd_en_n      = 1'b1;
                    end else begin
                        shreg_n  = {shreg[6:0], 1'b0};
                        bitcnt_n = bitcnt + 3'd1;
                    end
                end
            end
            DONE: begin
                load_pend_n = load_rise;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            hold       <= '0;
            bitcnt     <= '0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            bytes_sent <= '0;
            rd_en_d    <= 1'b0;
            load_pend  <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            hold       <= hold_n;
            bitcnt     <= bitcnt_n;
            rd_en      <= rd_en_n;
            rd_addr    <= rd_addr_n;
            bytes_sent <= bytes_sent_n;
            rd_en_d    <= rd_en;
            load_pend  <= load_pend_n;
        end
    end

    assign sdo       = (state == SHIFT) & shreg[7];
    assign busy      = (state == PREFETCH) || (state == SHIFT);
    assign xfer_done = (state == DONE);

endmodule

// File: tb/tb_spi_readback_tx.sv
// Directed bench: an MCU model clocks frames out of a 4-byte buffer and checks bits,
// buffer addresses, byte counts and the done pulse.
module tb_spi_readback_tx;

    localparam int NB = 4;
    localparam int AW = 2;

    logic          sysclk = 1'b0;
    logic          reset  = 1'b0;
    logic          sck    = 1'b0;
    logic          load   = 1'b0;
    logic          sdo;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data = 8'h00;
    logic          busy;
    logic          xfer_done;
    logic [AW:0]   bytes_sent;

    logic [7:0]    mem [NB];
    logic          bits [$];
    logic [AW-1:0] addr_log [$];
    int            done_cnt = 0;
    int            n_asserts = 0;
    int            n_fail = 0;
    int            bb, ba, dc;

    spi_readback_tx #(.NUM_BYTES(NB), .AW(AW), .SYNC_STAGES(2)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .sck        (sck),
        .load       (load),
        .sdo        (sdo),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .xfer_done  (xfer_done),
        .bytes_sent (bytes_sent)
    );

    always #10 sysclk = ~sysclk;

    // synchronous-read buffer model plus read-address and done-pulse monitors
    always @(posedge sysclk) begin
        if (rd_en === 1'b1) begin
            rd_data <= mem[rd_addr];
            addr_log.push_back(rd_addr);
        end
        if (xfer_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MCU samples sdo just before each sck rise; sck phases are 200 ns
    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            bits.push_back(sdo);
            sck = 1'b1;
            #200;
            sck = 1'b0;
            #200;
        end
    endtask

    function automatic logic [7:0] byte_at(input int base, input int idx);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[7-k] = bits[base + 8*idx + k];
        return b;
    endfunction

    initial begin
        mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;

        // reset asserted mid-cycle, outputs checked before any clock edge
        #3 reset = 1'b1;
        #2;
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_rd_en", 32'(rd_en), 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_xfer_done", 32'(xfer_done), 32'h0);
        check("rst_bytes_sent", 32'(bytes_sent), 32'h0);
        #68 reset = 1'b0;
        #100;

        // single byte A5
        bb = bits.size(); dc = done_cnt;
        load = 1'b1;
        #200;
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_bs_start", 32'(bytes_sent), 32'h0);
        clock_bits(8);
        check("t1_byte", 32'(byte_at(bb, 0)), 32'hA5);
        #200 load = 1'b0;
        #400;
        check("t1_done_pulse", 32'(done_cnt - dc), 32'h1);
        check("t1_bytes_sent", 32'(bytes_sent), 32'h1);
        check("t1_busy_idle", 32'(busy), 32'h0);
        check("t1_sdo_idle", 32'(sdo), 32'h0);

        // three bytes, read address sequence 0,1,2,3 then wrap to 0
        mem[0] = 8'h01; mem[1] = 8'h80; mem[2] = 8'hFF;
        bb = bits.size(); ba = addr_log.size(); dc = done_cnt;
        load = 1'b1;
        #200;
        check("t2_bs_cleared", 32'(bytes_sent), 32'h0);
        clock_bits(24);
        check("t2_byte0", 32'(byte_at(bb, 0)), 32'h01);
        check("t2_byte1", 32'(byte_at(bb, 1)), 32'h80);
        check("t2_byte2", 32'(byte_at(bb, 2)), 32'hFF);
        check("t2_reads", 32'(addr_log.size() - ba), 32'd5);
        for (int i = 0; i < 4; i++) check("t2_addr", 32'(addr_log[ba + i]), 32'(i));
        check("t2_addr_wrap", 32'(addr_log[ba + 4]), 32'h0);
        #200 load = 1'b0;
        #400;
        check("t2_done_pulse", 32'(done_cnt - dc), 32'h1);
        check("t2_bytes_sent", 32'(bytes_sent), 32'h3);

        // 40 bits over a 4-byte buffer repeats byte 0
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        bb = bits.size();
        load = 1'b1;
        #200;
        clock_bits(40);
        check("t3_byte0", 32'(byte_at(bb, 0)), 32'h11);
        check("t3_byte1", 32'(byte_at(bb, 1)), 32'h22);
        check("t3_byte2", 32'(byte_at(bb, 2)), 32'h33);
        check("t3_byte3", 32'(byte_at(bb, 3)), 32'h44);
        check("t3_byte4", 32'(byte_at(bb, 4)), 32'h11);
        #200 load = 1'b0;
        #400;
        check("t3_bytes_sent", 32'(bytes_sent), 32'h5);

        // abort after 3 sck falls: partial byte not counted
        bb = bits.size(); dc = done_cnt;
        load = 1'b1;
        #200;
        clock_bits(3);
        check("t4_bits", 32'({bits[bb], bits[bb+1], bits[bb+2]}), 32'h0);
        #200 load = 1'b0;
        #400;
        check("t4_done_pulse", 32'(done_cnt - dc), 32'h1);
        check("t4_bytes_sent", 32'(bytes_sent), 32'h0);
        check("t4_sdo_idle", 32'(sdo), 32'h0);
        check("t4_busy_idle", 32'(busy), 32'h0);

        // reset after 12 bits, then a clean frame from address 0
        mem[0] = 8'h80; mem[1] = 8'hFF;
        dc = done_cnt;
        load = 1'b1;
        #200;
        clock_bits(12);
        check("t5_bs_pre_rst", 32'(bytes_sent), 32'h1);
        check("t5_sdo_pre_rst", 32'(sdo), 32'h1);
        reset = 1'b1;
        load  = 1'b0;
        #2;
        check("t5_rst_sdo", 32'(sdo), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_bytes_sent", 32'(bytes_sent), 32'h0);
        check("t5_rst_rd_addr", 32'(rd_addr), 32'h0);
        #68 reset = 1'b0;
        #10;
        #400;
        check("t5_no_done", 32'(done_cnt - dc), 32'h0);
        mem[0] = 8'hC3;
        bb = bits.size(); ba = addr_log.size(); dc = done_cnt;
        load = 1'b1;
        #200;
        check("t5_restart_addr", 32'(addr_log[ba]), 32'h0);
        check("t5_restart_bs", 32'(bytes_sent), 32'h0);
        clock_bits(8);
        check("t5_byte", 32'(byte_at(bb, 0)), 32'hC3);
        #200 load = 1'b0;
        #400;
        check("t5_done_pulse", 32'(done_cnt - dc), 32'h1);
        check("t5_bytes_sent", 32'(bytes_sent), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
